// File: rtl/chess_pkg.sv
// rtl/chess_pkg.sv - shared sound codes, note constants and the note-sequence ROM
package chess_pkg;

  localparam logic [2:0] SND_NONE      = 3'd0;
  localparam logic [2:0] SND_SELECT    = 3'd1;
  localparam logic [2:0] SND_MOVE      = 3'd2;
  localparam logic [2:0] SND_WHITE_WIN = 3'd3;
  localparam logic [2:0] SND_BLACK_WIN = 3'd4;

  localparam int FREQ_A5 = 880;
  localparam int FREQ_E5 = 659;
  localparam int FREQ_C5 = 523;
  localparam int FREQ_G5 = 784;

  localparam int GAP_MS      = 10;
  localparam int MAX_DUR_MS  = 150;
  localparam int DUR_W       = $clog2(MAX_DUR_MS + 1);

  typedef enum logic [1:0] {IDLE, TONE, GAP} state_e;
  typedef enum logic [1:0] {NOTE_A5, NOTE_E5, NOTE_C5, NOTE_G5} note_e;

  typedef struct packed {
    note_e            note;
    logic [DUR_W-1:0] dur_ms;
    logic             last;
  } seq_entry_t;

  function automatic int half_period(int clk_freq, int f);
    return clk_freq / (2 * f);
  endfunction

  function automatic logic valid_code(logic [2:0] code);
    return (code >= SND_SELECT) && (code <= SND_BLACK_WIN);
  endfunction

  // Unlisted {code, index} pairs are never reached while playing.
  function automatic seq_entry_t seq_rom(logic [2:0] code, logic [1:0] idx);
    seq_entry_t e;
    e = '{note: NOTE_A5, dur_ms: DUR_W'(80), last: 1'b1};
    case ({code, idx})
      {SND_SELECT, 2'd0}:    e = '{note: NOTE_A5, dur_ms: DUR_W'(80),  last: 1'b1};
      {SND_MOVE, 2'd0}:      e = '{note: NOTE_E5, dur_ms: DUR_W'(60),  last: 1'b0};
      {SND_MOVE, 2'd1}:      e = '{note: NOTE_A5, dur_ms: DUR_W'(60),  last: 1'b1};
      {SND_WHITE_WIN, 2'd0}: e = '{note: NOTE_C5, dur_ms: DUR_W'(150), last: 1'b0};
      {SND_WHITE_WIN, 2'd1}: e = '{note: NOTE_E5, dur_ms: DUR_W'(150), last: 1'b0};
      {SND_WHITE_WIN, 2'd2}: e = '{note: NOTE_G5, dur_ms: DUR_W'(150), last: 1'b1};
      {SND_BLACK_WIN, 2'd0}: e = '{note: NOTE_G5, dur_ms: DUR_W'(150), last: 1'b0};
      {SND_BLACK_WIN, 2'd1}: e = '{note: NOTE_E5, dur_ms: DUR_W'(150), last: 1'b0};
      {SND_BLACK_WIN, 2'd2}: e = '{note: NOTE_C5, dur_ms: DUR_W'(150), last: 1'b1};
      default:               e = '{note: NOTE_A5, dur_ms: DUR_W'(80),  last: 1'b1};
    endcase
    return e;
  endfunction

endpackage

// File: rtl/tone_gen.sv
// rtl/tone_gen.sv - square-wave generator; restart begins a high half-period
module tone_gen #(
  parameter int HP_W = 10
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            en,
  input  logic            restart,
  input  logic [HP_W-1:0] half_period,
  output logic            wave
);

  logic [HP_W-1:0] cnt_q, cnt_d;
  logic            wave_q, wave_d;

  always_comb begin
    cnt_d  = cnt_q;
    wave_d = wave_q;
    if (!en) begin
      cnt_d  = '0;
      wave_d = 1'b0;
    end else if (restart) begin
      cnt_d  = '0;
      wave_d = 1'b1;
    end else if (cnt_q == half_period - HP_W'(1)) begin
      cnt_d  = '0;
      wave_d = ~wave_q;
    end else begin
      cnt_d  = cnt_q + HP_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q  <= '0;
      wave_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      wave_q <= wave_d;
    end
  end

  assign wave = wave_q;

endmodule

// File: rtl/chess_sound_player.sv
// rtl/chess_sound_player.sv - plays fixed note sequences per sound code on the PWM audio pin
module chess_sound_player
  import chess_pkg::*;
#(
  parameter int CLK_FREQ  = 100_000_000,
  parameter int MS_CYCLES = CLK_FREQ / 1000
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [2:0] sound_code,
  input  logic       play_sound,
  output logic       audio_pwm,
  output logic       audio_sd,
  output logic       busy
);

  localparam int HP_A5 = half_period(CLK_FREQ, FREQ_A5);
  localparam int HP_E5 = half_period(CLK_FREQ, FREQ_E5);
  localparam int HP_C5 = half_period(CLK_FREQ, FREQ_C5);
  localparam int HP_G5 = half_period(CLK_FREQ, FREQ_G5);
  localparam int HP_W  = $clog2(HP_C5 + 1);
  localparam int MS_W  = $clog2(MS_CYCLES + 1);

  state_e           state_q, state_d;
  logic [2:0]       code_q, code_d;
  logic [1:0]       idx_q, idx_d;
  logic [MS_W-1:0]  ms_q, ms_d;
  logic [DUR_W-1:0] tick_q, tick_d;

  seq_entry_t      cur;
  logic [HP_W-1:0] hp;
  logic            ms_wrap;
  logic            tone_en;
  logic            tone_restart;

  always_comb begin
    cur          = seq_rom(code_q, idx_q);
    state_d      = state_q;
    code_d       = code_q;
    idx_d        = idx_q;
    ms_d         = ms_q;
    tick_d       = tick_q;
    tone_restart = 1'b0;
    ms_wrap      = (ms_q == MS_W'(MS_CYCLES - 1));

    // A valid request always wins, even on the cycle the last note ends.
    if (play_sound && valid_code(sound_code)) begin
      state_d      = TONE;
      code_d       = sound_code;
      idx_d        = 2'd0;
      ms_d         = '0;
      tick_d       = '0;
      tone_restart = 1'b1;
    end else begin
      case (state_q)
        TONE: begin
          if (ms_wrap) begin
            ms_d = '0;
            if (tick_q == cur.dur_ms - DUR_W'(1)) begin
              tick_d  = '0;
              state_d = cur.last ? IDLE : GAP;
            end else begin
              tick_d = tick_q + DUR_W'(1);
            end
          end else begin
            ms_d = ms_q + MS_W'(1);
          end
        end
        GAP: begin
          if (ms_wrap) begin
            ms_d = '0;
            if (tick_q == DUR_W'(GAP_MS - 1)) begin
              tick_d       = '0;
              state_d      = TONE;
              idx_d        = idx_q + 2'd1;
              tone_restart = 1'b1;
            end else begin
              tick_d = tick_q + DUR_W'(1);
            end
          end else begin
            ms_d = ms_q + MS_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // Gating on the next state silences the pin on the very edge a note ends.
    tone_en = (state_d == TONE);

    case (cur.note)
      NOTE_A5: hp = HP_W'(HP_A5);
      NOTE_E5: hp = HP_W'(HP_E5);
      NOTE_C5: hp = HP_W'(HP_C5);
      default: hp = HP_W'(HP_G5);
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      code_q  <= SND_NONE;
      idx_q   <= 2'd0;
      ms_q    <= '0;
      tick_q  <= '0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      idx_q   <= idx_d;
      ms_q    <= ms_d;
      tick_q  <= tick_d;
    end
  end

  tone_gen #(.HP_W(HP_W)) u_tone_gen (
    .clk         (clk),
    .rstn        (rstn),
    .en          (tone_en),
    .restart     (tone_restart),
    .half_period (hp),
    .wave        (audio_pwm)
  );

  assign busy     = (state_q != IDLE);
  assign audio_sd = busy;

endmodule

// File: tb/tb_chess_sound_player.sv
// tb/tb_chess_sound_player.sv - self-checking bench for chess_sound_player
module tb_chess_sound_player;

  localparam int CLK_FREQ  = 20_000;
  localparam int MS_CYCLES = 20;
  localparam int GAP_CYC   = 10 * MS_CYCLES;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic [2:0] sound_code = 3'd0;
  logic       play_sound = 1'b0;
  logic       audio_pwm, audio_sd, busy;

  int checks = 0;
  int errors = 0;
  int m_code = 0;
  int m_t    = 0;

  chess_sound_player #(.CLK_FREQ(CLK_FREQ), .MS_CYCLES(MS_CYCLES)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .sound_code (sound_code),
    .play_sound (play_sound),
    .audio_pwm  (audio_pwm),
    .audio_sd   (audio_sd),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Expected {busy, pwm} at cycle t after a sequence starts, from the note list.
  function automatic logic [1:0] model(int code, int t);
    int fr[3];
    int du[3];
    int n;
    int len;
    int hp;
    n  = 0;
    fr = '{1, 1, 1};
    du = '{0, 0, 0};
    case (code)
      1: begin n = 1; fr[0] = 880; du[0] = 80; end
      2: begin n = 2; fr[0] = 659; du[0] = 60; fr[1] = 880; du[1] = 60; end
      3: begin n = 3; fr = '{523, 659, 784}; du = '{150, 150, 150}; end
      4: begin n = 3; fr = '{784, 659, 523}; du = '{150, 150, 150}; end
      default: n = 0;
    endcase
    for (int i = 0; i < n; i++) begin
      len = du[i] * MS_CYCLES;
      hp  = CLK_FREQ / (2 * fr[i]);
      if (t < len) return {1'b1, ((t / hp) % 2) == 0};
      t -= len;
      if (i < n - 1) begin
        if (t < GAP_CYC) return 2'b10;
        t -= GAP_CYC;
      end
    end
    return 2'b00;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0d code=%0d)", name, act, exp, m_t, m_code);
    end
  endtask

  // One clock: drive inputs, advance the model, compare after the edge.
  task automatic cyc(input logic ps, input logic [2:0] c);
    logic [1:0] e;
    play_sound = ps;
    sound_code = c;
    @(posedge clk);
    #1;
    if (ps && c >= 3'd1 && c <= 3'd4) begin
      m_code = int'(c);
      m_t    = 0;
    end else if (m_code != 0) begin
      m_t++;
    end
    e = model(m_code, m_t);
    if (!e[1]) m_code = 0;
    chk("model", {29'd0, audio_sd, busy, audio_pwm}, {29'd0, e[1], e[1], e[0]});
    play_sound = 1'b0;
  endtask

  task automatic do_reset();
    #2;
    rstn = 1'b0;
    #1;
    chk("rst_pwm", {31'd0, audio_pwm}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_sd", {31'd0, audio_sd}, 32'd0);
    m_code = 0;
    m_t    = 0;
    @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  typedef struct {
    logic [2:0] code;
    int         t;
    logic       pwm;
    logic       busy;
  } vec_t;

  vec_t vecs[16];
  bit   dropped;

  initial begin
    vecs[0]  = '{3'd1, 0,    1'b1, 1'b1};
    vecs[1]  = '{3'd1, 10,   1'b1, 1'b1};
    vecs[2]  = '{3'd1, 11,   1'b0, 1'b1};
    vecs[3]  = '{3'd1, 22,   1'b1, 1'b1};
    vecs[4]  = '{3'd1, 1599, 1'b0, 1'b1};
    vecs[5]  = '{3'd1, 1600, 1'b0, 1'b0};
    vecs[6]  = '{3'd2, 1199, 1'b0, 1'b1};
    vecs[7]  = '{3'd2, 1200, 1'b0, 1'b1};
    vecs[8]  = '{3'd2, 1399, 1'b0, 1'b1};
    vecs[9]  = '{3'd2, 1400, 1'b1, 1'b1};
    vecs[10] = '{3'd2, 1411, 1'b0, 1'b1};
    vecs[11] = '{3'd2, 2599, 1'b0, 1'b1};
    vecs[12] = '{3'd2, 2600, 1'b0, 1'b0};
    vecs[13] = '{3'd3, 19,   1'b0, 1'b1};
    vecs[14] = '{3'd3, 3215, 1'b0, 1'b1};
    vecs[15] = '{3'd4, 9400, 1'b0, 1'b0};

    @(posedge clk);
    #1;
    do_reset();

    for (int i = 0; i < 16; i++) begin
      do_reset();
      cyc(1'b1, vecs[i].code);
      repeat (vecs[i].t) cyc(1'b0, 3'd0);
      chk($sformatf("vec%0d_pwm", i), {31'd0, audio_pwm}, {31'd0, vecs[i].pwm});
      chk($sformatf("vec%0d_busy", i), {31'd0, busy}, {31'd0, vecs[i].busy});
    end

    // Reset mid-tone, then silence with no further request.
    do_reset();
    cyc(1'b1, 3'd3);
    repeat (500) cyc(1'b0, 3'd0);
    do_reset();
    repeat (2000) cyc(1'b0, 3'd0);

    // Reserved code in idle, then a reserved strobe during code 4.
    cyc(1'b1, 3'd5);
    chk("reserved_idle", {31'd0, busy}, 32'd0);
    cyc(1'b1, 3'd4);
    repeat (1000) cyc(1'b0, 3'd0);
    cyc(1'b1, 3'd0);
    repeat (8500) cyc(1'b0, 3'd0);

    // Code 2 interrupts code 3 partway through the first note.
    cyc(1'b1, 3'd3);
    repeat (600) cyc(1'b0, 3'd0);
    cyc(1'b1, 3'd2);
    chk("restart_pwm", {31'd0, audio_pwm}, 32'd1);
    repeat (2700) cyc(1'b0, 3'd0);

    // Back-to-back request on the last cycle of a code 1 tone.
    dropped = 1'b0;
    cyc(1'b1, 3'd1);
    repeat (1599) begin
      cyc(1'b0, 3'd0);
      if (!busy) dropped = 1'b1;
    end
    cyc(1'b1, 3'd1);
    if (!busy) dropped = 1'b1;
    chk("b2b_busy_held", {31'd0, dropped}, 32'd0);
    chk("b2b_pwm", {31'd0, audio_pwm}, 32'd1);
    repeat (1700) cyc(1'b0, 3'd0);

    // Random requests with noise on sound_code.
    for (int i = 0; i < 20000; i++) begin
      if ($urandom_range(0, 599) == 0) cyc(1'b1, 3'($urandom_range(0, 7)));
      else cyc(1'b0, 3'($urandom_range(0, 7)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
